execute_unit: RTL and testbench
===============================

# execute_unit

Parametrised execute stage for the pipelined core. It sits between the ID/EX and EX/MEM pipeline registers. It forwards operands from EX/MEM and MEM/WB, and executes single-cycle integer ops (add/sub/logic/shift/compare). It also runs iterative multi-cycle MUL/DIVU/REMU and stalls the front end through a valid/ready handshake while they are in progress.

## Interface
- XLEN, 32, datapath width; must be ≥8 and a power of two.
- RADDR, 5, register-address width.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ID/EX holds a real instruction.
- in_ready  out  1  Unit accepts this cycle. Accept = in_valid & in_ready at a clk edge.
- in_pc  in  XLEN  instruction PC; passed through only.
- in_rs1data, in_rs2data  in  XLEN  register-file read data.
- in_rs1, in_rs2, in_rd  in  RADDR  source and destination register numbers.
- in_imm  in  XLEN  sign-extended immediate.
- in_func7  in  7  instruction funct7 field.
- in_func3  in  3  instruction funct3 field.
- in_alusrc  in  1  1 = operand B is in_imm.
- in_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- in_regwrite  in  1  instruction writes rd.
- memwb_regwrite  in  1  MEM/WB write-enable.
- memwb_rd  in  RADDR  MEM/WB destination register.
- wb_data  in  XLEN  write-back mux output.
- exmem_valid, exmem_regwrite  out  1  EX/MEM valid and write-enable.
- exmem_rd  out  RADDR  EX/MEM destination register.
- exmem_alu  out  XLEN  EX/MEM result.
- exmem_reg2  out  XLEN  forwarded rs2 value, used as store data.
- exmem_zero  out  1  1 when exmem_alu is 0.
- busy  out  1  multi-cycle op in progress; equals ~in_ready.

## Operation
- **Forwarding**, per source operand, evaluated combinationally:
  - EX/MEM wins when exmem_valid & exmem_regwrite & exmem_rd≠0 & exmem_rd==rs.
  - Otherwise MEM/WB is used when memwb_regwrite & memwb_rd≠0 & memwb_rd==rs.
  - Otherwise the register-file data is used.
  - Register 0 is never forwarded.
- **Operand B** = in_alusrc ? in_imm : forwarded rs2.
- **Op decode:**
  - aluop 00 → ADD. aluop 01 → SUB.
  - aluop 10/11 → RV32 funct3 decode: 000 ADD (SUB when aluop 10 and func7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (func7[5]), 110 OR, 111 AND.
  - Shift amount is B[log2(XLEN)-1:0].
- **M ops:** aluop 10 with func7=0000001 selects MUL (func3 000, low XLEN bits), DIVU (101) or REMU (111). Any other func3 gives result 0 as a single-cycle op.
- **States:** IDLE and BUSY; cnt is a log2(XLEN)+1-bit counter.
- **IDLE:**
  - in_ready=1.
  - On accept of a single-cycle op: load EX/MEM with valid=1, rd, result, forwarded rs2, zero, regwrite.
  - On accept of an M op: latch both forwarded operands, rd and regwrite; set cnt=0; go to BUSY; load an EX/MEM bubble.
  - With no accept: load an EX/MEM bubble.
  - A bubble is valid=0, regwrite=0, rd=0, alu=0, reg2=0, zero=0.
- **BUSY:**
  - in_ready=0; an EX/MEM bubble is loaded each edge.
  - While cnt<XLEN: one shift-add (MUL) or restoring (DIVU/REMU) iteration per edge, then cnt+1.
  - At cnt==XLEN: load EX/MEM with the result and the latched rd, regwrite and rs2; go to IDLE.
- **Divide by zero:** DIVU returns all-ones; REMU returns the dividend. No exception is raised.
- **Upstream obligations:**
  - ID/EX holds all in_* stable while in_ready=0.
  - Register-file read data is refreshed every stalled cycle.
  - Operands are sampled only on the accept edge.
- **Reset:** reset=1 at an edge forces IDLE, cnt=0 and an EX/MEM bubble, aborting any M op. The aborted result is never written.

## Timing
- **Reset values:** exmem_valid=0, exmem_regwrite=0, exmem_rd=0, exmem_alu=0, exmem_reg2=0, exmem_zero=0; busy=0, in_ready=1.
- **Single-cycle op:** result is in EX/MEM at the accept edge (latency 1). Back-to-back accepts are allowed.
- **M op accepted at edge E0:**
  - Iterations run at edges E1..E_XLEN.
  - The result is loaded into EX/MEM at E_(XLEN+1).
  - in_ready is low in the cycles between E0 and E_(XLEN+1) (XLEN+1 cycles).
  - The next accept is possible at E_(XLEN+2) at the earliest.
- **Dependent instruction after an M op:** it is accepted at E_(XLEN+2) and forwards from EX/MEM.
- **Bubble cycles:** EX/MEM is never forwarded from while it holds a bubble.
- **Simultaneous EX/MEM and MEM/WB match:** EX/MEM is used.

## Test plan
- **Reset:** hold reset 2 cycles → all exmem_* outputs 0, in_ready=1. Assert reset at cnt=10 of a MUL → IDLE next edge, exmem_valid never rises for that MUL.
- **Forward priority:** ADD x3=5+7 then ADD x4=x3+x3 back-to-back with memwb_rd=3, wb_data=99 → exmem_alu=12 then 24; exmem_zero=0.
- **Single-cycle ops, XLEN=32:**
  - SUB 5−5 → alu 0, zero=1.
  - SRA 0x80000000 by imm 4 → 0xF8000000.
  - SLTU 1<0xFFFFFFFF → 1.
  - SLT 1<−1 → 0.
- **MUL:** 0x0001_0003 × 0x0002_0005 → exmem_alu=0x000B_000F with exmem_valid=1 exactly 33 edges after accept; in_ready=0 for 33 cycles; in_valid held.
- **Divide:** DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- **Register 0:** rd=0 with regwrite=1 in EX/MEM and a dependent source rs1=0 → register-file data is used, not forwarded.

Source files
------------

// File: rtl/execute_unit_if.sv
`default_nettype none
// ============================================================================
// execute_unit_if : ID/EX issue, MEM/WB forwarding and EX/MEM result bundle
// Revision 1.0
// ============================================================================
interface execute_unit_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1data;
    logic [XLEN-1:0]  in_rs2data;
    logic [RADDR-1:0] in_rs1;
    logic [RADDR-1:0] in_rs2;
    logic [RADDR-1:0] in_rd;
    logic [XLEN-1:0]  in_imm;
    logic [6:0]       in_func7;
    logic [2:0]       in_func3;
    logic             in_alusrc;
    logic [1:0]       in_aluop;
    logic             in_regwrite;
    logic             memwb_regwrite;
    logic [RADDR-1:0] memwb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             exmem_valid;
    logic             exmem_regwrite;
    logic [RADDR-1:0] exmem_rd;
    logic [XLEN-1:0]  exmem_alu;
    logic [XLEN-1:0]  exmem_reg2;
    logic             exmem_zero;
    logic             busy;

    modport master (
        output in_valid, in_pc, in_rs1data, in_rs2data, in_rs1, in_rs2, in_rd,
               in_imm, in_func7, in_func3, in_alusrc, in_aluop, in_regwrite,
               memwb_regwrite, memwb_rd, wb_data,
        input  in_ready, exmem_valid, exmem_regwrite, exmem_rd, exmem_alu,
               exmem_reg2, exmem_zero, busy
    );

    modport slave (
        input  in_valid, in_pc, in_rs1data, in_rs2data, in_rs1, in_rs2, in_rd,
               in_imm, in_func7, in_func3, in_alusrc, in_aluop, in_regwrite,
               memwb_regwrite, memwb_rd, wb_data,
        output in_ready, exmem_valid, exmem_regwrite, exmem_rd, exmem_alu,
               exmem_reg2, exmem_zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// execute_unit : forwarding EX stage, single-cycle ALU plus iterative MUL/DIVU/REMU
// Revision 1.0
// ============================================================================
module execute_unit #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic          clk,
    input  logic          reset,
    execute_unit_if.slave bus
);
    localparam int              c_SHW      = $clog2(XLEN);
    localparam int              c_CW       = c_SHW + 1;
    localparam logic [c_CW-1:0] c_CNT_DONE = c_CW'(XLEN);
    localparam logic [0:0]      c_S_IDLE   = 1'b0;
    localparam logic [0:0]      c_S_BUSY   = 1'b1;
    localparam logic [1:0]      c_MOP_MUL  = 2'd0;
    localparam logic [1:0]      c_MOP_DIVU = 2'd1;
    localparam logic [1:0]      c_MOP_REMU = 2'd2;

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [1:0]       r_mop;
    logic [XLEN-1:0]  r_opA;
    logic [XLEN-1:0]  r_opB;
    logic [XLEN-1:0]  r_acc;
    logic [RADDR-1:0] r_mRd;
    logic             r_mRegwrite;
    logic [XLEN-1:0]  r_mReg2;

    logic             r_exValid;
    logic             r_exRegwrite;
    logic [RADDR-1:0] r_exRd;
    logic [XLEN-1:0]  r_exAlu;
    logic [XLEN-1:0]  r_exReg2;
    logic             r_exZero;

    logic             w_accept;
    logic             w_exHitA, w_exHitB, w_wbHitA, w_wbHitB;
    logic [XLEN-1:0]  w_fwdA, w_fwdB, w_opB;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_aluRes;
    logic             w_isMop;
    logic [1:0]       w_mopSel;
    logic [XLEN:0]    w_trial;
    logic             w_qbit;
    logic [XLEN-1:0]  w_mResult;
    logic             w_unusedPc;

    assign w_unusedPc = ^bus.in_pc;

    // Bubbles carry valid=0, so an idle EX/MEM stage can never win forwarding.
    assign w_exHitA = r_exValid & r_exRegwrite & (r_exRd != '0) & (r_exRd == bus.in_rs1);
    assign w_exHitB = r_exValid & r_exRegwrite & (r_exRd != '0) & (r_exRd == bus.in_rs2);
    assign w_wbHitA = bus.memwb_regwrite & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.in_rs1);
    assign w_wbHitB = bus.memwb_regwrite & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.in_rs2);

    assign w_fwdA  = w_exHitA ? r_exAlu : (w_wbHitA ? bus.wb_data : bus.in_rs1data);
    assign w_fwdB  = w_exHitB ? r_exAlu : (w_wbHitB ? bus.wb_data : bus.in_rs2data);
    assign w_opB   = bus.in_alusrc ? bus.in_imm : w_fwdB;
    assign w_shamt = w_opB[c_SHW-1:0];

    assign w_accept = bus.in_valid & (r_state == c_S_IDLE);

    always_comb begin
        w_aluRes = '0;
        w_isMop  = 1'b0;
        w_mopSel = c_MOP_MUL;
        case (bus.in_aluop)
            2'b00: w_aluRes = w_fwdA + w_opB;
            2'b01: w_aluRes = w_fwdA - w_opB;
            default: begin
                if (bus.in_aluop == 2'b10 && bus.in_func7 == 7'b0000001) begin
                    case (bus.in_func3)
                        3'b000: begin w_isMop = 1'b1; w_mopSel = c_MOP_MUL;  end
                        3'b101: begin w_isMop = 1'b1; w_mopSel = c_MOP_DIVU; end
                        3'b111: begin w_isMop = 1'b1; w_mopSel = c_MOP_REMU; end
                        default: w_aluRes = '0;
                    endcase
                end else begin
                    case (bus.in_func3)
                        3'b000: begin
                            if (bus.in_aluop == 2'b10 && bus.in_func7 == 7'b0100000)
                                w_aluRes = w_fwdA - w_opB;
                            else
                                w_aluRes = w_fwdA + w_opB;
                        end
                        3'b001: w_aluRes = w_fwdA << w_shamt;
                        3'b010: w_aluRes = {{(XLEN-1){1'b0}}, ($signed(w_fwdA) < $signed(w_opB))};
                        3'b011: w_aluRes = {{(XLEN-1){1'b0}}, (w_fwdA < w_opB)};
                        3'b100: w_aluRes = w_fwdA ^ w_opB;
                        3'b101: begin
                            if (bus.in_func7[5])
                                w_aluRes = $signed(w_fwdA) >>> w_shamt;
                            else
                                w_aluRes = w_fwdA >> w_shamt;
                        end
                        3'b110: w_aluRes = w_fwdA | w_opB;
                        default: w_aluRes = w_fwdA & w_opB;
                    endcase
                end
            end
        endcase
    end

    // Restoring divide: r_acc is the partial remainder, r_opA shifts the dividend
    // out and the quotient in. A zero divisor naturally yields all-ones / dividend.
    assign w_trial   = {r_acc, r_opA[XLEN-1]} - {1'b0, r_opB};
    assign w_qbit    = ~w_trial[XLEN];
    assign w_mResult = (r_mop == c_MOP_DIVU) ? r_opA : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_exValid    <= 1'b0;
            r_exRegwrite <= 1'b0;
            r_exRd       <= '0;
            r_exAlu      <= '0;
            r_exReg2     <= '0;
            r_exZero     <= 1'b0;
        end else begin
            r_exValid    <= 1'b0;
            r_exRegwrite <= 1'b0;
            r_exRd       <= '0;
            r_exAlu      <= '0;
            r_exReg2     <= '0;
            r_exZero     <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept && w_isMop) begin
                        r_opA       <= w_fwdA;
                        r_opB       <= w_opB;
                        r_acc       <= '0;
                        r_mop       <= w_mopSel;
                        r_mRd       <= bus.in_rd;
                        r_mRegwrite <= bus.in_regwrite;
                        r_mReg2     <= w_fwdB;
                        r_cnt       <= '0;
                        r_state     <= c_S_BUSY;
                    end else if (w_accept) begin
                        r_exValid    <= 1'b1;
                        r_exRegwrite <= bus.in_regwrite;
                        r_exRd       <= bus.in_rd;
                        r_exAlu      <= w_aluRes;
                        r_exReg2     <= w_fwdB;
                        r_exZero     <= (w_aluRes == '0);
                    end
                end
                c_S_BUSY: begin
                    if (r_cnt != c_CNT_DONE) begin
                        if (r_mop == c_MOP_MUL) begin
                            if (r_opB[0])
                                r_acc <= r_acc + r_opA;
                            r_opA <= r_opA << 1;
                            r_opB <= r_opB >> 1;
                        end else begin
                            r_acc <= w_qbit ? w_trial[XLEN-1:0] : {r_acc[XLEN-2:0], r_opA[XLEN-1]};
                            r_opA <= {r_opA[XLEN-2:0], w_qbit};
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_exValid    <= 1'b1;
                        r_exRegwrite <= r_mRegwrite;
                        r_exRd       <= r_mRd;
                        r_exAlu      <= w_mResult;
                        r_exReg2     <= r_mReg2;
                        r_exZero     <= (w_mResult == '0);
                        r_state      <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == c_S_IDLE);
    assign bus.busy           = (r_state == c_S_BUSY);
    assign bus.exmem_valid    = r_exValid;
    assign bus.exmem_regwrite = r_exRegwrite;
    assign bus.exmem_rd       = r_exRd;
    assign bus.exmem_alu      = r_exAlu;
    assign bus.exmem_reg2     = r_exReg2;
    assign bus.exmem_zero     = r_exZero;
endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// tb_execute_unit : directed self-checking bench for execute_unit (XLEN=32)
// Revision 1.0
// ============================================================================
module tb_execute_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    execute_unit_if #(.XLEN(32), .RADDR(5)) bus ();

    execute_unit #(.XLEN(32), .RADDR(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_rs1data     = '0;
        bus.in_rs2data     = '0;
        bus.in_rs1         = '0;
        bus.in_rs2         = '0;
        bus.in_rd          = '0;
        bus.in_imm         = '0;
        bus.in_func7       = '0;
        bus.in_func3       = '0;
        bus.in_alusrc      = 1'b0;
        bus.in_aluop       = 2'b00;
        bus.in_regwrite    = 1'b0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = '0;
        bus.wb_data        = '0;
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm);
        bus.in_valid    = 1'b1;
        bus.in_pc       = 32'h0000_0100;
        bus.in_aluop    = aluop;
        bus.in_func3    = f3;
        bus.in_func7    = f7;
        bus.in_alusrc   = src;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_rd       = rd;
        bus.in_rs1data  = d1;
        bus.in_rs2data  = d2;
        bus.in_imm      = imm;
        bus.in_regwrite = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.exmem_valid, bus.exmem_regwrite, bus.exmem_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {bus.exmem_valid, bus.exmem_regwrite, bus.exmem_zero});
        end
        total++;
        if (bus.exmem_rd !== 5'd0 || bus.exmem_alu !== 32'd0 || bus.exmem_reg2 !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got rd=%0d alu=%h reg2=%h want 0", bus.exmem_rd, bus.exmem_alu, bus.exmem_reg2);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_forward();
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        bus.memwb_regwrite = 1'b1;
        bus.memwb_rd       = 5'd3;
        bus.wb_data        = 32'd99;
        @(posedge clk); #1;
        total++;
        if (bus.exmem_alu !== 32'd12 || bus.exmem_valid !== 1'b1 || bus.exmem_rd !== 5'd3 || bus.exmem_zero !== 1'b0) begin
            bad++;
            $display("FAIL fwd_first got alu=%0d v=%b rd=%0d z=%b want 12/1/3/0",
                     bus.exmem_alu, bus.exmem_valid, bus.exmem_rd, bus.exmem_zero);
        end
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.exmem_alu !== 32'd24 || bus.exmem_reg2 !== 32'd12 || bus.exmem_zero !== 1'b0) begin
            bad++;
            $display("FAIL fwd_exmem_priority got alu=%0d reg2=%0d z=%b want 24/12/0",
                     bus.exmem_alu, bus.exmem_reg2, bus.exmem_zero);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.exmem_valid, bus.exmem_regwrite, bus.exmem_zero} !== 3'b000 ||
            bus.exmem_rd !== 5'd0 || bus.exmem_alu !== 32'd0 || bus.exmem_reg2 !== 32'd0) begin
            bad++;
            $display("FAIL bubble got v=%b rd=%0d alu=%h reg2=%h want all 0",
                     bus.exmem_valid, bus.exmem_rd, bus.exmem_alu, bus.exmem_reg2);
        end
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.exmem_alu !== 32'd101) begin
            bad++;
            $display("FAIL fwd_memwb got=%0d want=101", bus.exmem_alu);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reg0();
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 32'd0);
        bus.memwb_regwrite = 1'b1;
        bus.memwb_rd       = 5'd0;
        bus.wb_data        = 32'd77;
        @(posedge clk); #1;
        total++;
        if (bus.exmem_valid !== 1'b1 || bus.exmem_rd !== 5'd0 || bus.exmem_alu !== 32'd12) begin
            bad++;
            $display("FAIL reg0_setup got v=%b rd=%0d alu=%0d want 1/0/12", bus.exmem_valid, bus.exmem_rd, bus.exmem_alu);
        end
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd0, 5'd2, 5'd8, 32'd3, 32'd1, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.exmem_alu !== 32'd4) begin
            bad++;
            $display("FAIL reg0_no_forward got=%0d want=4", bus.exmem_alu);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // {aluop, func3, func7, alusrc, a, b, imm, expected}
    logic [140:0] alu_vec [0:13];

    task automatic test_alu();
        logic [31:0] exp;
        alu_vec[0]  = {2'b10, 3'b000, 7'b0100000, 1'b0, 32'd5,          32'd5,          32'd0,          32'd0};
        alu_vec[1]  = {2'b11, 3'b101, 7'b0100000, 1'b1, 32'h8000_0000,  32'd0,          32'h0000_0404,  32'hF800_0000};
        alu_vec[2]  = {2'b10, 3'b011, 7'b0000000, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1};
        alu_vec[3]  = {2'b10, 3'b010, 7'b0000000, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0};
        alu_vec[4]  = {2'b00, 3'b010, 7'b0000000, 1'b1, 32'h100,        32'd0,          32'hFFFF_FFFC,  32'h0000_00FC};
        alu_vec[5]  = {2'b01, 3'b000, 7'b0000000, 1'b0, 32'd3,          32'd5,          32'd0,          32'hFFFF_FFFE};
        alu_vec[6]  = {2'b10, 3'b001, 7'b0000000, 1'b0, 32'd1,          32'd33,         32'd0,          32'd2};
        alu_vec[7]  = {2'b10, 3'b101, 7'b0000000, 1'b0, 32'h8000_0000,  32'd4,          32'd0,          32'h0800_0000};
        alu_vec[8]  = {2'b10, 3'b100, 7'b0000000, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0000_0FF0};
        alu_vec[9]  = {2'b10, 3'b110, 7'b0000000, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0000_FFF0};
        alu_vec[10] = {2'b10, 3'b111, 7'b0000000, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0000_F000};
        alu_vec[11] = {2'b10, 3'b010, 7'b0000001, 1'b0, 32'd7,          32'd9,          32'd0,          32'd0};
        alu_vec[12] = {2'b11, 3'b000, 7'b0100000, 1'b1, 32'd5,          32'd0,          32'd3,          32'd8};
        alu_vec[13] = {2'b10, 3'b010, 7'b0000000, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd1};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_op(alu_vec[i][140:139], alu_vec[i][138:136], alu_vec[i][135:129], alu_vec[i][128],
                   5'd1, 5'd2, 5'd10, alu_vec[i][127:96], alu_vec[i][95:64], alu_vec[i][63:32]);
            exp = alu_vec[i][31:0];
            @(posedge clk); #1;
            total++;
            if (bus.exmem_alu !== exp || bus.exmem_zero !== (exp == 32'd0) ||
                bus.exmem_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL alu[%0d] got alu=%h z=%b v=%b rdy=%b want alu=%h z=%b v=1 rdy=1",
                         i, bus.exmem_alu, bus.exmem_zero, bus.exmem_valid, bus.in_ready, exp, (exp == 32'd0));
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_mul();
        int lowCnt;
        int seen;
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'b0000001, 1'b0, 5'd1, 5'd2, 5'd6, 32'h0001_0003, 32'h0002_0005, 32'd0);
        @(posedge clk); #1;
        lowCnt = 0;
        seen   = -1;
        for (int k = 1; k <= 40 && seen < 0; k++) begin
            if (!bus.in_ready) lowCnt++;
            @(posedge clk); #1;
            if (bus.exmem_valid) seen = k;
        end
        total++;
        if (seen != 33) begin
            bad++;
            $display("FAIL mul_latency got=%0d want=33", seen);
        end
        total++;
        if (lowCnt != 33) begin
            bad++;
            $display("FAIL mul_stall_cycles got=%0d want=33", lowCnt);
        end
        total++;
        if (bus.exmem_alu !== 32'h000B_000F || bus.exmem_rd !== 5'd6 || bus.exmem_reg2 !== 32'h0002_0005) begin
            bad++;
            $display("FAIL mul_result got alu=%h rd=%0d reg2=%h want 000b000f/6/00020005",
                     bus.exmem_alu, bus.exmem_rd, bus.exmem_reg2);
        end
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'd0, 1'b0, 5'd6, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.exmem_alu !== 32'h000B_000F || bus.exmem_rd !== 5'd7) begin
            bad++;
            $display("FAIL mul_dependent got alu=%h rd=%0d want 000b000f/7", bus.exmem_alu, bus.exmem_rd);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // {func3, dividend, divisor, expected}
    logic [98:0] div_vec [0:5];

    task automatic test_div();
        int seen;
        div_vec[0] = {3'b101, 32'd100,         32'd7,         32'd14};
        div_vec[1] = {3'b111, 32'd100,         32'd7,         32'd2};
        div_vec[2] = {3'b101, 32'h1234_5678,   32'd0,         32'hFFFF_FFFF};
        div_vec[3] = {3'b111, 32'd9,           32'd0,         32'd9};
        div_vec[4] = {3'b101, 32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF};
        div_vec[5] = {3'b111, 32'hFFFF_FFFF,   32'h10,        32'h0000_000F};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(2'b10, div_vec[i][98:96], 7'b0000001, 1'b0, 5'd1, 5'd2, 5'd9,
                   div_vec[i][95:64], div_vec[i][63:32], 32'd0);
            @(posedge clk); #1;
            seen = -1;
            for (int k = 1; k <= 40 && seen < 0; k++) begin
                @(posedge clk); #1;
                if (bus.exmem_valid) seen = k;
            end
            total++;
            if (seen != 33) begin
                bad++;
                $display("FAIL div[%0d]_latency got=%0d want=33", i, seen);
            end
            total++;
            if (bus.exmem_alu !== div_vec[i][31:0]) begin
                bad++;
                $display("FAIL div[%0d]_result got=%h want=%h", i, bus.exmem_alu, div_vec[i][31:0]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_abort();
        logic rose;
        @(negedge clk);
        set_op(2'b10, 3'b000, 7'b0000001, 1'b0, 5'd1, 5'd2, 5'd11, 32'd3, 32'd4, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rose = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (bus.exmem_valid) rose = 1'b1;
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before got=%b want=1", bus.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle got busy=%b ready=%b want 0/1", bus.busy, bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.exmem_valid) rose = 1'b1;
        end
        total++;
        if (rose !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_writeback got valid_rose=%b want=0", rose);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_forward();
        test_reg0();
        test_alu();
        test_mul();
        test_div();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
